// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int ROW_W = 13;
    localparam int COL_W = 10;
    localparam int AW    = ROW_W + COL_W;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        DONE
    } arb_state_t;

    // Counter only has to reach TIMEOUT-1 before the timeout fires.
    function automatic int cnt_width(input int timeout);
        return (timeout < 3) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first request found after ptr, with wrap-around.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller between N_PORTS requesters and a reconfiguration requester,
// sequencing one transaction at a time on the controller's busy handshake.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int N_PORTS     = 4,
    parameter int BA_WIDTH    = 2,
    parameter int D_WIDTH     = 16,
    parameter int A_ROW_WIDTH = ROW_W,
    parameter int A_COL_WIDTH = AW - ROW_W,
    parameter int A_WIDTH     = 13,
    parameter int TIMEOUT     = 64
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic [N_PORTS-1:0]                           i_req,
    input  logic [N_PORTS-1:0]                           i_req_rw,
    input  logic [N_PORTS*(A_ROW_WIDTH+A_COL_WIDTH)-1:0] i_req_addr,
    input  logic [N_PORTS*BA_WIDTH-1:0]                  i_req_ba,
    input  logic [N_PORTS*D_WIDTH-1:0]                   i_req_wdata,
    output logic [N_PORTS-1:0]                           o_done,
    output logic                                         o_err,
    output logic [D_WIDTH-1:0]                           o_rd_data,
    output logic [N_PORTS-1:0]                           o_grant,
    input  logic                                         i_cfg_req,
    input  logic [A_WIDTH-1:0]                           i_cfg_mode,
    output logic                                         o_cfg_done,
    output logic                                         o_initial,
    output logic                                         o_rw,
    output logic [A_ROW_WIDTH+A_COL_WIDTH-1:0]           o_addr,
    output logic [BA_WIDTH-1:0]                          o_ba,
    output logic [D_WIDTH-1:0]                           o_wdata,
    output logic                                         o_reconfig,
    output logic [A_WIDTH-1:0]                           o_mode,
    input  logic                                         i_busy,
    input  logic [D_WIDTH-1:0]                           i_rdata
);

    localparam int ADDR_W = A_ROW_WIDTH + A_COL_WIDTH;
    localparam int IW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CW     = cnt_width(TIMEOUT);

    arb_state_t        state_q, state_d;
    logic              cfg_q;
    logic              err_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     ptr_q;

    logic [N_PORTS-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               start;
    logic               timeout_hit;

    logic               sel_rw;
    logic [ADDR_W-1:0]  sel_addr;
    logic [BA_WIDTH-1:0] sel_ba;
    logic [D_WIDTH-1:0] sel_wdata;

    rr_picker #(
        .N  (N_PORTS),
        .IW (IW)
    ) u_picker (
        .req (i_req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Busy low in IDLE also covers controller init and auto-refresh.
    assign start       = (state_q == IDLE) && !i_busy && (i_cfg_req || pick_any);
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    // AND-OR mux of the winning port's command fields.
    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_ba    = '0;
        sel_wdata = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (pick_gnt[p]) begin
                sel_rw    = i_req_rw[p];
                sel_addr  = i_req_addr[p*ADDR_W +: ADDR_W];
                sel_ba    = i_req_ba[p*BA_WIDTH +: BA_WIDTH];
                sel_wdata = i_req_wdata[p*D_WIDTH +: D_WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   state_d = WAIT_HI;
            WAIT_HI: begin
                if (i_busy)           state_d = WAIT_LO;
                else if (timeout_hit) state_d = DONE;
            end
            WAIT_LO: if (!i_busy) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_initial  = 1'b0;
        o_reconfig = 1'b0;
        o_done     = '0;
        o_cfg_done = 1'b0;
        o_err      = 1'b0;
        case (state_q)
            ISSUE: begin
                o_initial  = !cfg_q;
                o_reconfig = cfg_q;
            end
            DONE: begin
                o_done     = cfg_q ? '0 : o_grant;
                o_cfg_done = cfg_q;
                o_err      = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cfg_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= IW'(N_PORTS - 1);
            o_grant   <= '0;
            o_rw      <= 1'b0;
            o_addr    <= '0;
            o_ba      <= '0;
            o_wdata   <= '0;
            o_rd_data <= '0;
            o_mode    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (i_cfg_req) begin
                            cfg_q  <= 1'b1;
                            o_mode <= i_cfg_mode;
                        end else begin
                            cfg_q   <= 1'b0;
                            o_grant <= pick_gnt;
                            ptr_q   <= pick_idx;
                            o_rw    <= sel_rw;
                            o_addr  <= sel_addr;
                            o_ba    <= sel_ba;
                            o_wdata <= sel_wdata;
                        end
                    end
                end
                ISSUE: cnt_q <= '0;
                WAIT_HI: begin
                    if (!i_busy) begin
                        if (timeout_hit) err_q <= 1'b1;
                        else             cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT_LO: begin
                    if (!i_busy && !cfg_q && !o_rw) o_rd_data <= i_rdata;
                end
                DONE: begin
                    o_grant <= '0;
                    cfg_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a behavioural controller and bank memory model.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    localparam int NP  = 4;
    localparam int BAW = 2;
    localparam int DW  = 16;
    localparam int MW  = 13;
    localparam int TO  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NP-1:0]     req, req_rw;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*BAW-1:0] req_ba;
    logic [NP*DW-1:0]  req_wdata;
    logic [NP-1:0]     done, grant;
    logic              err, cfg_req, cfg_done, initial_o, rw, reconfig, busy;
    logic [DW-1:0]     rd_data, wdata, rdata;
    logic [MW-1:0]     cfg_mode, mode;
    logic [AW-1:0]     addr;
    logic [BAW-1:0]    ba;

    logic          req_b [NP];
    logic          p_rw  [NP];
    logic [AW-1:0] p_addr[NP];
    logic [BAW-1:0] p_ba [NP];
    logic [DW-1:0] p_wd  [NP];

    logic [DW-1:0] mem [logic [BAW+AW-1:0]];
    int checks = 0;
    int errors = 0;

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            req[i]                   = req_b[i];
            req_rw[i]                = p_rw[i];
            req_addr[i*AW +: AW]     = p_addr[i];
            req_ba[i*BAW +: BAW]     = p_ba[i];
            req_wdata[i*DW +: DW]    = p_wd[i];
        end
    end

    sdram_port_arbiter #(
        .N_PORTS(NP), .BA_WIDTH(BAW), .D_WIDTH(DW), .A_ROW_WIDTH(13),
        .A_COL_WIDTH(10), .A_WIDTH(MW), .TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_rw(req_rw),
        .i_req_addr(req_addr), .i_req_ba(req_ba), .i_req_wdata(req_wdata),
        .o_done(done), .o_err(err), .o_rd_data(rd_data), .o_grant(grant),
        .i_cfg_req(cfg_req), .i_cfg_mode(cfg_mode), .o_cfg_done(cfg_done),
        .o_initial(initial_o), .o_rw(rw), .o_addr(addr), .o_ba(ba),
        .o_wdata(wdata), .o_reconfig(reconfig), .o_mode(mode),
        .i_busy(busy), .i_rdata(rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Contents of never-written locations in the memory model.
    function automatic logic [DW-1:0] fill(input logic [BAW+AW-1:0] key);
        return DW'(key) ^ 16'h5a5a;
    endfunction

    task automatic set_port(input int p, input logic r, input logic [AW-1:0] a,
                            input logic [BAW-1:0] b, input logic [DW-1:0] d);
        p_rw[p]   = r;
        p_addr[p] = a;
        p_ba[p]   = b;
        p_wd[p]   = d;
    endtask

    task automatic wait_issue(input string tag, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (initial_o || reconfig) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " issue_seen"}, 32'(seen), 32'd1);
    endtask

    // One complete transaction with the controller model holding busy for busy_cycles.
    task automatic do_txn(input int p, input bit cfg, input int busy_cycles, input string tag);
        bit                seen;
        logic [BAW+AW-1:0] key;
        logic              r;
        logic [DW-1:0]     rd_exp;
        r      = 1'b1;
        rd_exp = '0;
        wait_issue(tag, seen);
        if (!seen) return;
        if (cfg) begin
            check({tag, " reconfig"}, 32'(reconfig), 32'd1);
            check({tag, " initial_low"}, 32'(initial_o), 32'd0);
            check({tag, " grant_idle"}, 32'(grant), 32'd0);
        end else begin
            check({tag, " grant"}, 32'(grant), 32'(NP'(1) << p));
            check({tag, " addr"}, 32'(addr), 32'(p_addr[p]));
            check({tag, " ba"}, 32'(ba), 32'(p_ba[p]));
            check({tag, " rw"}, 32'(rw), 32'(p_rw[p]));
            key = {ba, addr};
            r   = rw;
            if (r) begin
                check({tag, " wdata"}, 32'(wdata), 32'(p_wd[p]));
                mem[key] = wdata;
            end else begin
                rd_exp = mem.exists(key) ? mem[key] : fill(key);
            end
        end
        busy = 1'b1;
        repeat (busy_cycles) @(negedge clk);
        check({tag, " single_pulse"}, 32'(initial_o | reconfig), 32'd0);
        if (!cfg) check({tag, " addr_stable"}, 32'(addr), 32'(p_addr[p]));
        busy = 1'b0;
        if (!r) rdata = rd_exp;
        @(negedge clk);
        if (cfg) begin
            check({tag, " cfg_done"}, 32'(cfg_done), 32'd1);
            cfg_req = 1'b0;
        end else begin
            check({tag, " done"}, 32'(done), 32'(NP'(1) << p));
            check({tag, " err"}, 32'(err), 32'd0);
            if (!r) check({tag, " rd_data"}, 32'(rd_data), 32'(rd_exp));
            req_b[p] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        int lat;
        rst      = 1'b0;
        busy     = 1'b0;
        rdata    = '0;
        cfg_req  = 1'b0;
        cfg_mode = '0;
        for (int i = 0; i < NP; i++) begin
            req_b[i] = 1'b0;
            set_port(i, 1'b0, '0, '0, '0);
        end
        repeat (3) @(negedge clk);
        check("rst grant", 32'(grant), 32'd0);
        check("rst initial", 32'(initial_o | reconfig), 32'd0);
        check("rst done", 32'({done, cfg_done, err}), 32'd0);
        check("rst addr", 32'(addr), 32'd0);
        check("rst mode", 32'(mode), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Port 1 write: bank 2, addr 5, data beef.
        set_port(1, 1'b1, 23'd5, 2'd2, 16'hbeef);
        req_b[1] = 1'b1;
        do_txn(1, 1'b0, 4, "t1");
        check("t1 model bank2[5]", 32'(mem[{2'd2, 23'd5}]), 32'h0000beef);

        // Fresh pointer: ports 0, 2, 3 reads held together, then all four.
        do_reset();
        for (int i = 0; i < NP; i++) set_port(i, 1'b0, 23'(100 + 16 * i), 2'(i), '0);
        req_b[0] = 1'b1;
        req_b[2] = 1'b1;
        req_b[3] = 1'b1;
        do_txn(0, 1'b0, 3, "t2a p0");
        do_txn(2, 1'b0, 2, "t2a p2");
        do_txn(3, 1'b0, 5, "t2a p3");
        for (int i = 0; i < NP; i++) req_b[i] = 1'b1;
        do_txn(0, 1'b0, 2, "t2b p0");
        do_txn(1, 1'b0, 2, "t2b p1");
        do_txn(2, 1'b0, 2, "t2b p2");
        do_txn(3, 1'b0, 2, "t2b p3");

        // Port 0 reads back the earlier write.
        set_port(0, 1'b0, 23'd5, 2'd2, '0);
        req_b[0] = 1'b1;
        do_txn(0, 1'b0, 3, "t3");
        check("t3 beef", 32'(rd_data), 32'h0000beef);
        repeat (3) @(negedge clk);
        check("t3 held", 32'(rd_data), 32'h0000beef);

        // Reconfiguration and port 2 requested in the same cycle.
        set_port(2, 1'b1, 23'd9, 2'd1, 16'h1234);
        cfg_mode = 13'b0001000100001;
        cfg_req  = 1'b1;
        req_b[2] = 1'b1;
        wait_issue("t4 cfg", seen);
        check("t4 reconfig first", 32'(reconfig), 32'd1);
        check("t4 mode", 32'(mode), 32'(13'b0001000100001));
        busy = 1'b1;
        repeat (3) @(negedge clk);
        check("t4 no port grant", 32'(grant), 32'd0);
        busy = 1'b0;
        @(negedge clk);
        check("t4 cfg_done", 32'(cfg_done), 32'd1);
        check("t4 no done", 32'(done), 32'd0);
        cfg_req = 1'b0;
        do_txn(2, 1'b0, 2, "t4 p2");

        // Controller never raises busy: timeout after TIMEOUT+1 cycles.
        set_port(3, 1'b0, 23'd7, 2'd0, '0);
        req_b[3] = 1'b1;
        wait_issue("t5", seen);
        lat = 0;
        for (int k = 1; k <= TO + 5; k++) begin
            @(negedge clk);
            if (done != '0) begin
                lat = k;
                break;
            end
        end
        check("t5 latency", 32'(lat), 32'(TO + 1));
        check("t5 done", 32'(done), 32'h8);
        check("t5 err", 32'(err), 32'd1);
        req_b[3] = 1'b0;
        @(negedge clk);
        check("t5 err pulse", 32'({done, err}), 32'd0);

        // Reset during WAIT_LO.
        set_port(1, 1'b1, 23'd11, 2'd3, 16'h0f0f);
        req_b[1] = 1'b1;
        wait_issue("t6", seen);
        busy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6 initial", 32'({initial_o, reconfig}), 32'd0);
        check("t6 grant", 32'(grant), 32'd0);
        check("t6 done", 32'({done, cfg_done, err}), 32'd0);
        check("t6 cmd", 32'({rw, ba, addr}), 32'd0);
        check("t6 data", 32'({wdata, rd_data}), 32'd0);
        check("t6 mode", 32'(mode), 32'd0);
        busy = 1'b0;
        for (int i = 0; i < NP; i++) req_b[i] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_txn(0, 1'b0, 2, "t6 first");
        for (int i = 0; i < NP; i++) req_b[i] = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
